fb_frame_sched: RTL and testbench

- Frame scheduler for the double-buffered framebuffer in the animated-shapes designs; runs in the system clock domain.
- Per frame flag: swaps front/back buffers, clears the back buffer, starts the renderer and waits for it to finish.
- Owns the shared framebuffer write port and routes each write to the back-buffer BRAM only.
- Counts frames that arrive while a previous frame is still being produced.

---
 rtl/fb_frame_sched.sv | 116 +++++++++++
 tb/tb_fb_frame_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_frame_sched.sv
// Frame scheduler for a double-buffered framebuffer: swaps buffers, clears the
// back buffer, kicks the renderer and routes all writes to the back buffer.
module fb_frame_sched #(
  parameter int unsigned FB_PIXELS  = 57600,
  parameter int unsigned ADDRW      = 16,
  parameter int unsigned DATAW      = 4,
  parameter int unsigned CLEAR_COLR = 0,
  parameter bit          CLEAR_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  output logic             render_start,
  input  logic             render_done,
  input  logic             render_we,
  input  logic [ADDRW-1:0] render_addr,
  input  logic [DATAW-1:0] render_colr,
  output logic [ADDRW-1:0] fb_addr,
  output logic [DATAW-1:0] fb_colr,
  output logic             fb_we_0,
  output logic             fb_we_1,
  output logic             fb_front,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [2:0] {IDLE, SWAP, CLEAR, DRAW, DONE} state_t;

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(FB_PIXELS - 1);
  localparam logic [DATAW-1:0] CLR_COLR  = DATAW'(CLEAR_COLR);

  state_t             state_q;
  logic [ADDRW-1:0]   cnt_q;
  logic               front_q;
  logic [7:0]         drop_q;
  logic               start_q;
  logic               we0_q, we1_q;
  logic [ADDRW-1:0]   addr_q;
  logic [DATAW-1:0]   colr_q;

  logic               req_d;
  logic [ADDRW-1:0]   addr_d;
  logic [DATAW-1:0]   colr_d;

  // Single write-request source: clear engine in CLEAR, renderer only in DRAW.
  always_comb begin
    req_d  = 1'b0;
    addr_d = cnt_q;
    colr_d = CLR_COLR;
    if (state_q == CLEAR) begin
      req_d = 1'b1;
    end else if (state_q == DRAW) begin
      req_d  = render_we;
      addr_d = render_addr;
      colr_d = render_colr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      front_q <= 1'b0;
      drop_q  <= '0;
      start_q <= 1'b0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      addr_q  <= '0;
      colr_q  <= '0;
    end else begin
      start_q <= 1'b0;
      we0_q   <= req_d & front_q;
      we1_q   <= req_d & ~front_q;
      if (req_d) begin
        addr_q <= addr_d;
        colr_q <= colr_d;
      end
      if (frame && state_q != IDLE && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      case (state_q)
        IDLE: if (frame) state_q <= SWAP;
        SWAP: begin
          front_q <= ~front_q;
          cnt_q   <= '0;
          if (CLEAR_EN) begin
            state_q <= CLEAR;
          end else begin
            state_q <= DRAW;
            start_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= DRAW;
            start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDRW'(1);
          end
        end
        DRAW: if (render_done) state_q <= DONE;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign render_start = start_q;
  assign fb_we_0      = we0_q;
  assign fb_we_1      = we1_q;
  assign fb_addr      = addr_q;
  assign fb_colr      = colr_q;
  assign fb_front     = front_q;
  assign drop_cnt     = drop_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fb_frame_sched.sv
// Directed bench for fb_frame_sched: a clearing instance (8 pixels) and a
// non-clearing instance share the clock.
module tb_fb_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, frame, render_done, render_we;
  logic [15:0] render_addr;
  logic [3:0]  render_colr;
  logic        rs, we0, we1, front, busy;
  logic [15:0] fa;
  logic [3:0]  fc;
  logic [7:0]  drop;

  logic        rst0_n, frame0, done0, rwe0;
  logic [15:0] raddr0;
  logic [3:0]  rcolr0;
  logic        rs0, we0_0, we1_0, front0, busy0;
  logic [15:0] fa0;
  logic [3:0]  fc0;
  logic [7:0]  drop0;

  fb_frame_sched #(.FB_PIXELS(8), .ADDRW(16), .DATAW(4), .CLEAR_COLR(10), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .render_start(rs), .render_done(render_done),
    .render_we(render_we), .render_addr(render_addr), .render_colr(render_colr),
    .fb_addr(fa), .fb_colr(fc), .fb_we_0(we0), .fb_we_1(we1), .fb_front(front),
    .busy(busy), .drop_cnt(drop));

  fb_frame_sched #(.FB_PIXELS(8), .ADDRW(16), .DATAW(4), .CLEAR_COLR(10), .CLEAR_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .frame(frame0), .render_start(rs0), .render_done(done0),
    .render_we(rwe0), .render_addr(raddr0), .render_colr(rcolr0),
    .fb_addr(fa0), .fb_colr(fc0), .fb_we_0(we0_0), .fb_we_1(we1_0), .fb_front(front0),
    .busy(busy0), .drop_cnt(drop0));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        frame;
    logic        we;
    logic [15:0] addr;
    logic [3:0]  colr;
    logic        done;
    logic        e_we0;
    logic        e_we1;
    logic [15:0] e_addr;
    logic [3:0]  e_colr;
    logic        e_front;
    logic        e_rs;
    logic        e_busy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // First frame: stray render_we in IDLE (c0) and CLEAR (c5), render write at c10, done at c13.
    tbl[0]  = '{1'b1, 1'b1, 16'd3,  4'd3,  1'b0, 1'b0, 1'b0, 16'd0, 4'd0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b0, 1'b0, 16'd0, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b0, 1'b0, 16'd0, 4'd0,  1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b1, 1'b0, 16'd0, 4'd10, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b1, 1'b0, 16'd1, 4'd10, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 16'd15, 4'd15, 1'b0, 1'b1, 1'b0, 16'd2, 4'd10, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b1, 1'b0, 16'd3, 4'd10, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b1, 1'b0, 16'd4, 4'd10, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b1, 1'b0, 16'd5, 4'd10, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b1, 1'b0, 16'd6, 4'd10, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 16'd5,  4'd9,  1'b0, 1'b1, 1'b0, 16'd7, 4'd10, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b1, 1'b0, 16'd5, 4'd9,  1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b0, 1'b0, 16'd5, 4'd9,  1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b1, 1'b0, 1'b0, 16'd5, 4'd9,  1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b0, 1'b0, 16'd5, 4'd9,  1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 16'd0,  4'd0,  1'b0, 1'b0, 1'b0, 16'd5, 4'd9,  1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; frame = 1'b0; render_done = 1'b0; render_we = 1'b0;
    render_addr = '0; render_colr = '0;
    rst0_n = 1'b0; frame0 = 1'b0; done0 = 1'b0; rwe0 = 1'b0; raddr0 = '0; rcolr0 = '0;
    repeat (3) tick();

    check("rst front", 32'(front), 32'd0);
    check("rst we0", 32'(we0), 32'd0);
    check("rst we1", 32'(we1), 32'd0);
    check("rst addr", 32'(fa), 32'd0);
    check("rst colr", 32'(fc), 32'd0);
    check("rst start", 32'(rs), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst drop", 32'(drop), 32'd0);
    check("rst0 busy", 32'(busy0), 32'd0);
    check("rst0 front", 32'(front0), 32'd0);
    rst_n = 1'b1;
    rst0_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      frame = tbl[i].frame; render_we = tbl[i].we; render_addr = tbl[i].addr;
      render_colr = tbl[i].colr; render_done = tbl[i].done;
      check($sformatf("f1 c%0d we0", i), 32'(we0), 32'(tbl[i].e_we0));
      check($sformatf("f1 c%0d we1", i), 32'(we1), 32'(tbl[i].e_we1));
      check($sformatf("f1 c%0d addr", i), 32'(fa), 32'(tbl[i].e_addr));
      check($sformatf("f1 c%0d colr", i), 32'(fc), 32'(tbl[i].e_colr));
      check($sformatf("f1 c%0d front", i), 32'(front), 32'(tbl[i].e_front));
      check($sformatf("f1 c%0d start", i), 32'(rs), 32'(tbl[i].e_rs));
      check($sformatf("f1 c%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      tick();
    end
    frame = 1'b0; render_we = 1'b0; render_done = 1'b0;
    check("f1 drop", 32'(drop), 32'd0);

    // Second frame writes to buffer 1; frames at t5 (CLEAR), t11 (DRAW), t13 (DONE) are dropped.
    for (int t = 0; t < 16; t++) begin
      frame = (t == 0 || t == 5 || t == 11 || t == 13);
      render_we = (t == 11); render_addr = 16'd2; render_colr = 4'd6;
      render_done = (t == 12);
      check($sformatf("f2 t%0d we0", t), 32'(we0), 32'd0);
      check($sformatf("f2 t%0d we1", t), 32'(we1), 32'((t >= 3 && t <= 10) || t == 12));
      if (t >= 3 && t <= 10) begin
        check($sformatf("f2 t%0d addr", t), 32'(fa), 32'(t - 3));
        check($sformatf("f2 t%0d colr", t), 32'(fc), 32'd10);
      end
      if (t == 12) begin
        check("f2 render addr", 32'(fa), 32'd2);
        check("f2 render colr", 32'(fc), 32'd6);
      end
      check($sformatf("f2 t%0d front", t), 32'(front), (t < 2) ? 32'd1 : 32'd0);
      check($sformatf("f2 t%0d start", t), 32'(rs), 32'(t == 10));
      check($sformatf("f2 t%0d busy", t), 32'(busy), 32'(t >= 1 && t <= 13));
      tick();
    end
    frame = 1'b0; render_we = 1'b0; render_done = 1'b0;
    check("f2 drop", 32'(drop), 32'd3);

    // Frame held high: one accepted, 300 dropped; count must saturate.
    frame = 1'b1;
    repeat (301) tick();
    frame = 1'b0;
    check("sat drop", 32'(drop), 32'd255);
    check("sat busy", 32'(busy), 32'd1);
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    begin
      int unsigned waited = 0;
      while (busy && waited < 20) begin
        tick();
        waited++;
      end
      check("sat idle wait", 32'(busy), 32'd0);
    end
    check("sat front", 32'(front), 32'd1);
    check("sat drop hold", 32'(drop), 32'd255);

    // Reset while clear address 4 is being issued.
    frame = 1'b1;
    tick();
    frame = 1'b0;
    repeat (5) tick();
    check("mid t6 we1", 32'(we1), 32'd1);
    check("mid t6 addr", 32'(fa), 32'd3);
    rst_n = 1'b0;
    tick();
    frame = 1'b1;
    check("mid rst we0", 32'(we0), 32'd0);
    check("mid rst we1", 32'(we1), 32'd0);
    check("mid rst addr", 32'(fa), 32'd0);
    check("mid rst colr", 32'(fc), 32'd0);
    check("mid rst start", 32'(rs), 32'd0);
    check("mid rst front", 32'(front), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst drop", 32'(drop), 32'd0);
    tick();
    rst_n = 1'b1;
    frame = 1'b0;
    check("mid frame-in-reset busy", 32'(busy), 32'd0);
    tick();
    check("mid post busy", 32'(busy), 32'd0);
    check("mid post we1", 32'(we1), 32'd0);

    // No-clear instance: frame at c0, render write at c2, done at c3.
    for (int c = 0; c < 7; c++) begin
      frame0 = (c == 0);
      rwe0 = (c == 2); raddr0 = 16'd7; rcolr0 = 4'd1;
      done0 = (c == 3);
      check($sformatf("nc c%0d start", c), 32'(rs0), 32'(c == 2));
      check($sformatf("nc c%0d we0", c), 32'(we0_0), 32'(c == 3));
      check($sformatf("nc c%0d we1", c), 32'(we1_0), 32'd0);
      check($sformatf("nc c%0d front", c), 32'(front0), 32'(c >= 2));
      check($sformatf("nc c%0d busy", c), 32'(busy0), 32'(c >= 1 && c <= 4));
      if (c == 3) begin
        check("nc addr", 32'(fa0), 32'd7);
        check("nc colr", 32'(fc0), 32'd1);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
